// File: rtl/ace_snoop_pkg.sv
// ACE snoop channel structs shared by the snoop responder and its CCU-side peer.
// Field widths assume a 64-bit snoop address and 64-bit CD beats.
package ace_snoop_pkg;

    typedef struct packed {
        logic [63:0] addr;
        logic [3:0]  snoop;
    } ac_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } cd_chan_t;

    typedef struct packed {
        ac_chan_t ac;
        logic     ac_valid;
        logic     cr_ready;
        logic     cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic       ac_ready;
        logic       cr_valid;
        logic [4:0] cr_resp;
        logic       cd_valid;
        cd_chan_t   cd;
    } snoop_resp_t;

endpackage

// File: rtl/ace_snoop_responder.sv
// Cache-side ACE snoop responder: AC -> cache lookup -> CR -> optional CD line -> state update.
// Optional ACE_SNOOP_CD_CRITICAL_WORD_FIRST_EN starts CD at the addressed beat and wraps.
module ace_snoop_responder #(
    parameter int unsigned DcacheLineWidth = 128,
    parameter int unsigned AxiDataWidth    = 64,
    parameter int unsigned AddrWidth       = 64,
    parameter type snoop_req_t  = ace_snoop_pkg::snoop_req_t,
    parameter type snoop_resp_t = ace_snoop_pkg::snoop_resp_t
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  snoop_req_t                 snoop_req_i,
    output snoop_resp_t                snoop_resp_o,
    output logic                       lookup_req_o,
    output logic [AddrWidth-1:0]       lookup_addr_o,
    input  logic                       lookup_gnt_i,
    input  logic                       lookup_valid_i,
    input  logic                       lookup_hit_i,
    input  logic                       lookup_dirty_i,
    input  logic                       lookup_shared_i,
    input  logic [DcacheLineWidth-1:0] lookup_data_i,
    output logic                       update_valid_o,
    output logic [1:0]                 update_op_o,
    output logic                       busy_o
);

    localparam int unsigned LineBeats = DcacheLineWidth / AxiDataWidth;
    localparam int unsigned BeatW     = (LineBeats > 1) ? $clog2(LineBeats) : 1;
    localparam int unsigned OffW      = $clog2(DcacheLineWidth / 8);
    localparam int unsigned BeatOffW  = $clog2(AxiDataWidth / 8);

    localparam logic [1:0] OpNone      = 2'd0;
    localparam logic [1:0] OpInval     = 2'd1;
    localparam logic [1:0] OpMakeShCln = 2'd2;
    localparam logic [1:0] OpClean     = 2'd3;

    typedef enum logic [2:0] {StIdle, StLookup, StWait, StSendCr, StSendCd, StUpdate} state_e;

    state_e                     state_q;
    logic [AddrWidth-1:OffW]    line_addr_q;
    logic [3:0]                 snoop_q;
    logic [DcacheLineWidth-1:0] line_q;
    logic [4:0]                 cr_q, cr_d;
    logic [1:0]                 op_q, op_d;
    logic [BeatW-1:0]           beat_q, last_beat_q, start_beat, beat_nxt;
    logic                       ac_ready_q, lookup_req_q, cr_valid_q, cd_valid_q, update_valid_q;
    logic [OffW-1:0]            unused_addr_low;

    assign unused_addr_low = snoop_req_i.ac.addr[OffW-1:0];

`ifdef ACE_SNOOP_CD_CRITICAL_WORD_FIRST_EN
    assign start_beat = (LineBeats > 1) ? BeatW'(snoop_req_i.ac.addr >> BeatOffW) : '0;
`else
    assign start_beat = '0;
`endif

    assign beat_nxt = (LineBeats > 1) ? beat_q + 1'b1 : '0;

    // CR bits: [0]DataTransfer [1]Error [2]PassDirty [3]IsShared [4]WasUnique
    always_comb begin
        cr_d = '0;
        op_d = OpNone;
        if (lookup_hit_i) begin
            case (snoop_q)
                4'b0000: cr_d = 5'b01001;
                4'b0001, 4'b0010, 4'b0011: begin
                    cr_d = {1'b0, 1'b1, lookup_dirty_i, 1'b0, 1'b1};
                    op_d = OpMakeShCln;
                end
                4'b0111: begin
                    cr_d = {~lookup_shared_i, 1'b0, lookup_dirty_i, 1'b0, 1'b1};
                    op_d = OpInval;
                end
                4'b1001: begin
                    cr_d = {~lookup_shared_i, 1'b0, lookup_dirty_i, 1'b0, lookup_dirty_i};
                    op_d = OpInval;
                end
                4'b1101: op_d = OpInval;
                4'b1000: begin
                    cr_d = {1'b0, 1'b1, lookup_dirty_i, 1'b0, lookup_dirty_i};
                    op_d = OpClean;
                end
                default: cr_d = 5'b00010;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            line_addr_q    <= '0;
            snoop_q        <= '0;
            line_q         <= '0;
            cr_q           <= '0;
            op_q           <= OpNone;
            beat_q         <= '0;
            last_beat_q    <= '0;
            ac_ready_q     <= 1'b1;
            lookup_req_q   <= 1'b0;
            cr_valid_q     <= 1'b0;
            cd_valid_q     <= 1'b0;
            update_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (snoop_req_i.ac_valid) begin
                        line_addr_q  <= snoop_req_i.ac.addr[AddrWidth-1:OffW];
                        snoop_q      <= snoop_req_i.ac.snoop;
                        beat_q       <= start_beat;
                        last_beat_q  <= (LineBeats > 1) ? start_beat - 1'b1 : '0;
                        ac_ready_q   <= 1'b0;
                        lookup_req_q <= 1'b1;
                        state_q      <= StLookup;
                    end
                end
                StLookup: begin
                    if (lookup_gnt_i) begin
                        lookup_req_q <= 1'b0;
                        state_q      <= StWait;
                    end
                end
                StWait: begin
                    if (lookup_valid_i) begin
                        line_q     <= lookup_data_i;
                        cr_q       <= cr_d;
                        op_q       <= op_d;
                        cr_valid_q <= 1'b1;
                        state_q    <= StSendCr;
                    end
                end
                StSendCr: begin
                    if (snoop_req_i.cr_ready) begin
                        cr_valid_q <= 1'b0;
                        if (cr_q[0]) begin
                            cd_valid_q <= 1'b1;
                            state_q    <= StSendCd;
                        end else begin
                            update_valid_q <= 1'b1;
                            state_q        <= StUpdate;
                        end
                    end
                end
                StSendCd: begin
                    if (snoop_req_i.cd_ready) begin
                        if (beat_q == last_beat_q) begin
                            cd_valid_q     <= 1'b0;
                            update_valid_q <= 1'b1;
                            state_q        <= StUpdate;
                        end else begin
                            beat_q <= beat_nxt;
                        end
                    end
                end
                StUpdate: begin
                    update_valid_q <= 1'b0;
                    ac_ready_q     <= 1'b1;
                    state_q        <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        snoop_resp_o          = '0;
        snoop_resp_o.ac_ready = ac_ready_q;
        snoop_resp_o.cr_valid = cr_valid_q;
        snoop_resp_o.cr_resp  = cr_q;
        snoop_resp_o.cd_valid = cd_valid_q;
        snoop_resp_o.cd.data  = line_q[beat_q*AxiDataWidth +: AxiDataWidth];
        snoop_resp_o.cd.last  = cd_valid_q & (beat_q == last_beat_q);
    end

    assign lookup_req_o   = lookup_req_q;
    assign lookup_addr_o  = {line_addr_q, {OffW{1'b0}}};
    assign update_valid_o = update_valid_q;
    assign update_op_o    = op_q;
    assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder; acts as both CCU and L1 cache with fixed-latency stimulus.
module tb_ace_snoop_responder;
    import ace_snoop_pkg::*;

`ifdef ACE_SNOOP_CD_CRITICAL_WORD_FIRST_EN
    localparam bit Cwf = 1'b1;
`else
    localparam bit Cwf = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    snoop_req_t   req;
    snoop_resp_t  resp;
    logic         lookup_req;
    logic [63:0]  lookup_addr;
    logic         gnt, lvalid, hit, dirty, shared;
    logic [127:0] ldata;
    logic         upd_valid;
    logic [1:0]   upd_op;
    logic         busy;
    logic [63:0]  nxt_addr;
    logic [3:0]   nxt_snoop;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ace_snoop_responder dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .snoop_req_i    (req),
        .snoop_resp_o   (resp),
        .lookup_req_o   (lookup_req),
        .lookup_addr_o  (lookup_addr),
        .lookup_gnt_i   (gnt),
        .lookup_valid_i (lvalid),
        .lookup_hit_i   (hit),
        .lookup_dirty_i (dirty),
        .lookup_shared_i(shared),
        .lookup_data_i  (ldata),
        .update_valid_o (upd_valid),
        .update_op_o    (upd_op),
        .busy_o         (busy)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_of(input logic [127:0] line, input int start, input int b);
        int idx;
        idx = (start + b) % 2;
        return (idx == 1) ? line[127:64] : line[63:0];
    endfunction

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
    task automatic run_snoop(input string name, input logic [63:0] addr, input logic [3:0] snp,
                             input logic h, input logic d, input logic s, input logic [127:0] line,
                             input int stall, input logic [4:0] exp_cr, input logic [1:0] exp_op,
                             input bit hold, input bit rst_mid);
        int start;
        start = Cwf ? int'(addr[3]) : 0;
        req.ac.addr  = addr;
        req.ac.snoop = snp;
        req.ac_valid = 1'b1;
        check_eq($sformatf("%s.ac_ready_idle", name), resp.ac_ready, 1);
        @(negedge clk);
        if (hold) begin
            req.ac.addr  = nxt_addr;
            req.ac.snoop = nxt_snoop;
        end else begin
            req.ac_valid = 1'b0;
        end
        check_eq($sformatf("%s.lookup_req", name), lookup_req, 1);
        check_eq($sformatf("%s.lookup_addr", name), lookup_addr, {addr[63:4], 4'h0});
        check_eq($sformatf("%s.ac_ready_busy", name), resp.ac_ready, 0);
        check_eq($sformatf("%s.busy", name), busy, 1);
        gnt = 1'b1;
        @(negedge clk);
        gnt    = 1'b0;
        lvalid = 1'b1;
        hit    = h;
        dirty  = d;
        shared = s;
        ldata  = line;
        @(negedge clk);
        lvalid = 1'b0;
        hit    = 1'b0;
        dirty  = 1'b0;
        shared = 1'b0;
        ldata  = '0;
        check_eq($sformatf("%s.cr_valid", name), resp.cr_valid, 1);
        check_eq($sformatf("%s.cr_resp", name), resp.cr_resp, exp_cr);
        @(negedge clk);
        check_eq($sformatf("%s.cr_valid_stall", name), resp.cr_valid, 1);
        check_eq($sformatf("%s.cr_resp_stall", name), resp.cr_resp, exp_cr);
        check_eq($sformatf("%s.ac_ready_cr", name), resp.ac_ready, 0);
        req.cr_ready = 1'b1;
        @(negedge clk);
        req.cr_ready = 1'b0;
        check_eq($sformatf("%s.cr_valid_done", name), resp.cr_valid, 0);
        if (exp_cr[0]) begin
            for (int b = 0; b < 2; b++) begin
                if (rst_mid) begin
                    check_eq($sformatf("%s.cd_valid_pre_rst", name), resp.cd_valid, 1);
                    rst = 1'b1;
                    #1;
                    check_eq($sformatf("%s.rst_cd_valid", name), resp.cd_valid, 0);
                    check_eq($sformatf("%s.rst_update", name), upd_valid, 0);
                    check_eq($sformatf("%s.rst_ac_ready", name), resp.ac_ready, 1);
                    check_eq($sformatf("%s.rst_busy", name), busy, 0);
                    @(negedge clk);
                    rst = 1'b0;
                    for (int c = 0; c < 4; c++) begin
                        @(negedge clk);
                        check_eq($sformatf("%s.post_rst_out", name),
                                 {resp.cr_valid, resp.cd_valid, upd_valid, lookup_req, busy}, 0);
                    end
                    return;
                end
                for (int k = 0; k < stall; k++) begin
                    check_eq($sformatf("%s.cd_valid_stall%0d", name, b), resp.cd_valid, 1);
                    check_eq($sformatf("%s.cd_data_stall%0d", name, b), resp.cd.data,
                             beat_of(line, start, b));
                    check_eq($sformatf("%s.cd_last_stall%0d", name, b), resp.cd.last, (b == 1));
                    check_eq($sformatf("%s.upd_early%0d", name, b), upd_valid, 0);
                    @(negedge clk);
                end
                check_eq($sformatf("%s.cd_valid%0d", name, b), resp.cd_valid, 1);
                check_eq($sformatf("%s.cd_data%0d", name, b), resp.cd.data, beat_of(line, start, b));
                check_eq($sformatf("%s.cd_last%0d", name, b), resp.cd.last, (b == 1));
                req.cd_ready = 1'b1;
                @(negedge clk);
                req.cd_ready = 1'b0;
            end
        end
        check_eq($sformatf("%s.cd_valid_off", name), resp.cd_valid, 0);
        check_eq($sformatf("%s.upd_valid", name), upd_valid, 1);
        check_eq($sformatf("%s.upd_op", name), upd_op, exp_op);
        @(negedge clk);
        check_eq($sformatf("%s.upd_pulse", name), upd_valid, 0);
        check_eq($sformatf("%s.ac_ready_back", name), resp.ac_ready, 1);
        check_eq($sformatf("%s.idle", name), busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst       = 1'b1;
        req       = '0;
        gnt       = 1'b0;
        lvalid    = 1'b0;
        hit       = 1'b0;
        dirty     = 1'b0;
        shared    = 1'b0;
        ldata     = '0;
        nxt_addr  = '0;
        nxt_snoop = '0;
        @(negedge clk);
        @(negedge clk);
        check_eq("reset.ac_ready", resp.ac_ready, 1);
        check_eq("reset.outs", {resp.cr_valid, resp.cd_valid, resp.cd.last, lookup_req, upd_valid, busy}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_snoop("read_shared", 64'h1000, 4'b0001, 1, 1, 0,
                  128'hAAAA_0002_BBBB_0002_1111_0001_2222_0001, 0, 5'h0D, 2'd2, 0, 0);
        run_snoop("ru_miss", 64'h2040, 4'b0111, 0, 0, 0, 128'h5, 0, 5'h00, 2'd0, 0, 0);
        run_snoop("ru_stall", 64'h3000, 4'b0111, 1, 0, 0,
                  128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002, 5, 5'h11, 2'd1, 0, 0);
        nxt_addr  = 64'h4010;
        nxt_snoop = 4'b0001;
        run_snoop("unsupported", 64'h5000, 4'hF, 1, 1, 0, 128'h77, 0, 5'h02, 2'd0, 1, 0);
        run_snoop("queued_rs", 64'h4010, 4'b0001, 1, 0, 1,
                  128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 5'h09, 2'd2, 0, 0);
        run_snoop("clean_shared", 64'h6000, 4'b1000, 1, 1, 0,
                  128'h1234_0000_0000_5678_9ABC_0000_0000_DEF0, 1, 5'h0D, 2'd3, 0, 0);
        run_snoop("clean_inv_cln", 64'h7000, 4'b1001, 1, 0, 1, 128'h9, 0, 5'h00, 2'd1, 0, 0);
        run_snoop("clean_inv_dty", 64'h7080, 4'b1001, 1, 1, 0,
                  128'h0000_0000_0000_00C1_0000_0000_0000_00C0, 0, 5'h15, 2'd1, 0, 0);
        run_snoop("make_inv", 64'h8000, 4'b1101, 1, 1, 0, 128'hF, 0, 5'h00, 2'd1, 0, 0);
        run_snoop("rst_mid_cd", 64'h9000, 4'b0000, 1, 0, 0,
                  128'h0000_0000_0000_0B01_0000_0000_0000_0B00, 2, 5'h09, 2'd0, 0, 1);
        run_snoop("read_once_cwf", 64'h1008, 4'b0000, 1, 0, 0,
                  128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 5'h09, 2'd0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
